// File: rtl/imm_extend_pipe_if.sv
// Handshake and data bundle for the pipelined immediate-extension unit.
// The producer/consumer side (decode stage driving inputs, ALU-operand
// stage taking results) uses the master modport; the unit itself uses slave.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   imm;
    logic [1:0]        mode;
    logic [OUT_W-1:0]  base;
    logic              add_base;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [OUT_W-1:0]  out_ext;

    modport master (
        output in_valid,
        output imm,
        output mode,
        output base,
        output add_base,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ext
    );

    modport slave (
        input  in_valid,
        input  imm,
        input  mode,
        input  base,
        input  add_base,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ext
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate-extension unit for the multi-cycle MIPS datapath.
// Stage 1 captures the extended immediate together with the base operand and
// the add selector; stage 2 performs the optional base add and presents the
// result. A valid/ready handshake lets either end stall without losing or
// duplicating items, and results always leave in the order they arrived.
// OUT_W must be at least IN_W + BR_SHIFT so the branch shift never drops
// significant bits.
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    imm_extend_pipe_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'b00,
        MODE_SIGN   = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_UPPER  = 2'b11
    } mode_t;

    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] ext_next;

    logic             s1_valid;
    logic [OUT_W-1:0] s1_ext;
    logic [OUT_W-1:0] s1_base;
    logic             s1_add_base;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [OUT_W-1:0] out_ext_q;

    logic [OUT_W-1:0] s2_result;
    logic             s2_adv;
    logic             s1_adv;

    // Stage 2 may move whenever it is empty or its result is being taken;
    // stage 1 may move whenever it is empty or stage 2 is making room.
    // in_ready deliberately ignores in_valid so the producer never sees a loop.
    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ext   = out_ext_q;

    // Widen the raw immediate according to the decode-supplied mode.
    always_comb begin
        zero_ext             = '0;
        zero_ext[IN_W-1:0]   = bus.imm;
        sign_ext             = {OUT_W{bus.imm[IN_W-1]}};
        sign_ext[IN_W-1:0]   = bus.imm;
        ext_next             = zero_ext;
        case (mode_t'(bus.mode))
            MODE_ZERO:   ext_next = zero_ext;
            MODE_SIGN:   ext_next = sign_ext;
            MODE_BRANCH: ext_next = sign_ext << BR_SHIFT;
            MODE_UPPER:  ext_next = zero_ext << (OUT_W - IN_W);
            default:     ext_next = zero_ext;
        endcase
    end

    // Optional base add; wraps modulo 2^OUT_W and reports no carry.
    always_comb begin
        s2_result = s1_ext;
        if (s1_add_base) begin
            s2_result = s1_base + s1_ext;
        end
    end

    // Stage 1 register: samples the inputs whenever it is allowed to move,
    // so mode/add_base only matter at the moment of transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_ext      <= '0;
            s1_base     <= '0;
            s1_add_base <= 1'b0;
        end else if (s1_adv) begin
            s1_valid    <= bus.in_valid;
            s1_ext      <= ext_next;
            s1_base     <= bus.base;
            s1_add_base <= bus.add_base;
        end
    end

    // Stage 2 register: holds its result steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ext_q   <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            out_data_q  <= s2_result;
            out_ext_q   <= s1_ext;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed cases on the default build
// plus a randomised run on both the default and an 8-to-16-bit build.
module tb_imm_extend_pipe;

    typedef struct packed {
        logic [31:0] ext;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus_a ();
    imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) bus_b ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];

    logic        a_s1v = 1'b0, a_s2v = 1'b0, a_stalled = 1'b0;
    logic [31:0] a_held_data, a_held_ext;
    logic        b_s1v = 1'b0, b_s2v = 1'b0, b_stalled = 1'b0;
    logic [15:0] b_held_data, b_held_ext;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] extA(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (mode)
            2'b00:   return {16'h0000, imm};
            2'b01:   return s;
            2'b10:   return s * 32'd4;
            default: return {imm, 16'h0000};
        endcase
    endfunction

    function automatic logic [15:0] extB(input logic [7:0] imm, input logic [1:0] mode);
        logic [15:0] s;
        s = {{8{imm[7]}}, imm};
        case (mode)
            2'b00:   return {8'h00, imm};
            2'b01:   return s;
            2'b10:   return s * 16'd4;
            default: return {imm, 8'h00};
        endcase
    endfunction

    // Monitor for the default build: checks handshake timing, stall hold,
    // and scoreboard order; sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic s2m, s1m;
        if (rst) begin
            qa.delete();
            a_s1v = 1'b0; a_s2v = 1'b0; a_stalled = 1'b0;
        end else begin
            checkOutput("a_out_valid", 32'(bus_a.out_valid), 32'(a_s2v));
            checkOutput("a_in_ready", 32'(bus_a.in_ready), 32'(!(a_s1v && a_s2v && !bus_a.out_ready)));
            if (a_stalled) begin
                checkOutput("a_hold_data", bus_a.out_data, a_held_data);
                checkOutput("a_hold_ext", bus_a.out_ext, a_held_ext);
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (qa.size() == 0) begin
                    checkOutput("a_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    checkOutput("a_out_ext", bus_a.out_ext, e.ext);
                    checkOutput("a_out_data", bus_a.out_data, e.data);
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                e.ext  = extA(bus_a.imm, bus_a.mode);
                e.data = bus_a.add_base ? bus_a.base + e.ext : e.ext;
                qa.push_back(e);
            end
            a_stalled   = bus_a.out_valid && !bus_a.out_ready;
            a_held_data = bus_a.out_data;
            a_held_ext  = bus_a.out_ext;
            s2m = !a_s2v || bus_a.out_ready;
            s1m = !a_s1v || s2m;
            if (s2m) a_s2v = a_s1v;
            if (s1m) a_s1v = bus_a.in_valid;
        end
    end

    // Same monitor for the narrow build.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] x;
        logic s2m, s1m;
        if (rst) begin
            qb.delete();
            b_s1v = 1'b0; b_s2v = 1'b0; b_stalled = 1'b0;
        end else begin
            checkOutput("b_out_valid", 32'(bus_b.out_valid), 32'(b_s2v));
            checkOutput("b_in_ready", 32'(bus_b.in_ready), 32'(!(b_s1v && b_s2v && !bus_b.out_ready)));
            if (b_stalled) begin
                checkOutput("b_hold_data", 32'(bus_b.out_data), 32'(b_held_data));
                checkOutput("b_hold_ext", 32'(bus_b.out_ext), 32'(b_held_ext));
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                if (qb.size() == 0) begin
                    checkOutput("b_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    checkOutput("b_out_ext", 32'(bus_b.out_ext), e.ext);
                    checkOutput("b_out_data", 32'(bus_b.out_data), e.data);
                end
            end
            if (bus_b.in_valid && bus_b.in_ready) begin
                x      = extB(bus_b.imm, bus_b.mode);
                e.ext  = 32'(x);
                e.data = bus_b.add_base ? 32'(16'(bus_b.base + x)) : 32'(x);
                qb.push_back(e);
            end
            b_stalled   = bus_b.out_valid && !bus_b.out_ready;
            b_held_data = bus_b.out_data;
            b_held_ext  = bus_b.out_ext;
            s2m = !b_s2v || bus_b.out_ready;
            s1m = !b_s1v || s2m;
            if (s2m) b_s2v = b_s1v;
            if (s1m) b_s1v = bus_b.in_valid;
        end
    end

    // Drive one cycle on the default build and report whether it was accepted.
    task automatic applyStimulus(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                                 input logic [31:0] base, input logic add, input logic rdy,
                                 output logic accepted);
        bus_a.in_valid  = v;
        bus_a.imm       = imm;
        bus_a.mode      = mode;
        bus_a.base      = base;
        bus_a.add_base  = add;
        bus_a.out_ready = rdy;
        #1;
        accepted = v && bus_a.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idleB();
        bus_b.in_valid  = 1'b0;
        bus_b.imm       = '0;
        bus_b.mode      = 2'b00;
        bus_b.base      = '0;
        bus_b.add_base  = 1'b0;
        bus_b.out_ready = 1'b1;
    endtask

    logic [31:0] t1_exp [4];

    initial begin
        logic acc;
        int   idx;
        int   saw_stall;
        int   cyc;

        t1_exp[0] = 32'h00008001;
        t1_exp[1] = 32'hFFFF8001;
        t1_exp[2] = 32'hFFFE0004;
        t1_exp[3] = 32'h80010000;

        rst = 1'b1;
        idleB();
        bus_a.in_valid = 1'b0; bus_a.imm = '0; bus_a.mode = 2'b00;
        bus_a.base = '0; bus_a.add_base = 1'b0; bus_a.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state of both builds.
        checkOutput("rst_a_out_valid", 32'(bus_a.out_valid), 32'd0);
        checkOutput("rst_a_in_ready", 32'(bus_a.in_ready), 32'd1);
        checkOutput("rst_a_out_data", bus_a.out_data, 32'd0);
        checkOutput("rst_a_out_ext", bus_a.out_ext, 32'd0);
        checkOutput("rst_b_out_valid", 32'(bus_b.out_valid), 32'd0);
        checkOutput("rst_b_out_data", 32'(bus_b.out_data), 32'd0);

        // Each mode on 16'h8001, result two cycles after its input.
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                checkOutput("t1_valid", 32'(bus_a.out_valid), 32'd1);
                checkOutput("t1_data", bus_a.out_data, t1_exp[k-2]);
            end
            applyStimulus(k < 4, 16'h8001, 2'(k), 32'h0, 1'b0, 1'b1, acc);
        end

        // Branch target with base add.
        applyStimulus(1'b1, 16'hFFFF, 2'b10, 32'h00400010, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 16'h0000, 2'b00, 32'h0, 1'b0, 1'b1, acc);
        checkOutput("t2_valid", 32'(bus_a.out_valid), 32'd1);
        checkOutput("t2_ext", bus_a.out_ext, 32'hFFFFFFFC);
        checkOutput("t2_data", bus_a.out_data, 32'h0040000C);

        // Base add wraps modulo 2^32.
        applyStimulus(1'b1, 16'h0002, 2'b10, 32'hFFFFFFFC, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 16'h0000, 2'b00, 32'h0, 1'b0, 1'b1, acc);
        checkOutput("t3_data", bus_a.out_data, 32'h00000004);
        applyStimulus(1'b0, 16'h0000, 2'b00, 32'h0, 1'b0, 1'b1, acc);

        // Streaming 1..8 with the consumer stalled in cycles 3-6.
        idx = 0; saw_stall = 0; cyc = 0;
        while ((idx < 8 || qa.size() != 0) && cyc < 40) begin
            if (idx < 8 && !bus_a.in_ready) saw_stall = 1;
            applyStimulus(idx < 8, 16'(idx + 1), 2'b00, 32'h0, 1'b0, !(cyc >= 3 && cyc <= 6), acc);
            if (acc) idx++;
            cyc++;
        end
        checkOutput("t4_all_sent", 32'(idx), 32'd8);
        checkOutput("t4_drained", 32'(qa.size()), 32'd0);
        checkOutput("t4_saw_backpressure", 32'(saw_stall), 32'd1);

        // Fill both stages, then reset with a fresh input presented.
        applyStimulus(1'b1, 16'h1111, 2'b01, 32'h0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 16'h2222, 2'b01, 32'h0, 1'b0, 1'b0, acc);
        checkOutput("t5_full_in_ready", 32'(bus_a.in_ready), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h3333, 2'b01, 32'h0, 1'b0, 1'b0, acc);
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        #1;
        checkOutput("t5_out_valid", 32'(bus_a.out_valid), 32'd0);
        checkOutput("t5_out_data", bus_a.out_data, 32'd0);
        checkOutput("t5_out_ext", bus_a.out_ext, 32'd0);
        checkOutput("t5_in_ready", 32'(bus_a.in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 16'h0000, 2'b00, 32'h0, 1'b0, 1'b1, acc);
            checkOutput("t5_no_stale", 32'(bus_a.out_valid), 32'd0);
        end

        // Randomised traffic on both builds.
        for (int c = 0; c < 500; c++) begin
            bus_a.in_valid  = ($urandom_range(0, 3) != 0);
            bus_a.imm       = 16'($urandom);
            bus_a.mode      = 2'($urandom);
            bus_a.base      = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : 32'($urandom);
            bus_a.add_base  = 1'($urandom);
            bus_a.out_ready = ($urandom_range(0, 2) != 0);
            bus_b.in_valid  = ($urandom_range(0, 3) != 0);
            bus_b.imm       = 8'($urandom);
            bus_b.mode      = 2'($urandom);
            bus_b.base      = 16'($urandom);
            bus_b.add_base  = 1'($urandom);
            bus_b.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        idleB();
        cyc = 0;
        while ((qa.size() != 0 || qb.size() != 0) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("t6_a_drained", 32'(qa.size()), 32'd0);
        checkOutput("t6_b_drained", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
